// File: rtl/apb_mem_slave_if.sv
// rtl/apb_mem_slave_if.sv - APB completer bus bundle with master/slave modports
//
// Purpose : groups the APB select/enable/address/data request signals and the
//           ready/read-data/error response signals of one PSEL line.
// Signals : psel, penable, pwrite, paddr[ADDR_W], pwdata[DATA_W]  (master -> slave)
//           pready, prdata[DATA_W], pslverr                       (slave -> master)
interface apb_mem_slave_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_mem_slave.sv
// rtl/apb_mem_slave.sv - APB completer serving a byte-wide register memory with programmable wait states
//
// Purpose : decodes one PSEL line, latches the request at the setup phase,
//           inserts WAIT_CYCLES wait states, then answers with registered
//           PREADY/PRDATA/PSLVERR. Addresses >= DEPTH are flagged with PSLVERR;
//           such writes are dropped and such reads return 0.
// Ports   : i_pclk     - bus clock, rising-edge active
//           i_presetn  - asynchronous active-low reset (clears FSM, outputs, memory)
//           s_apb      - apb_mem_slave_if.slave (psel/penable/pwrite/paddr/pwdata in,
//                        pready/prdata/pslverr out)
module apb_mem_slave #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              i_pclk,
    input  logic              i_presetn,
    apb_mem_slave_if.slave    s_apb
);

    localparam int              IDX_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LP_DEPTH     = (ADDR_W + 1)'(DEPTH);
    // Counter is loaded with WAIT_CYCLES-1 so that the last wait cycle is cnt==0.
    localparam logic [3:0]      LP_WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam bit              LP_ZERO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    // Request latched at the setup phase; later bus changes are ignored.
    logic [IDX_W-1:0]  r_idx;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;
    logic              r_err;
    logic [3:0]        r_cnt;

    logic              r_pready;
    logic              r_pslverr;
    logic [DATA_W-1:0] r_prdata;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_setup;
    logic              w_addr_err;
    logic [IDX_W-1:0]  w_addr_idx;

    logic              w_latch;
    logic              w_mem_we;
    logic [3:0]        w_cnt_nxt;
    logic              w_pready_nxt;
    logic              w_pslverr_nxt;
    logic [DATA_W-1:0] w_prdata_nxt;

    assign w_setup    = s_apb.psel & ~s_apb.penable;
    assign w_addr_err = ({1'b0, s_apb.paddr} >= LP_DEPTH);
    assign w_addr_idx = s_apb.paddr[IDX_W-1:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                // A bare PENABLE without a preceding setup phase is ignored.
                if (w_setup) begin
                    w_state_nxt = LP_ZERO_WAIT ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!s_apb.psel) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath control: next values for the registered outputs,
    // the wait counter, the request latch and the memory write strobe.
    // ------------------------------------------------------------------
    always_comb begin
        w_latch       = 1'b0;
        w_mem_we      = 1'b0;
        w_cnt_nxt     = r_cnt;
        w_pready_nxt  = 1'b0;
        w_pslverr_nxt = 1'b0;
        w_prdata_nxt  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_setup) begin
                    w_latch = 1'b1;
                    if (LP_ZERO_WAIT) begin
                        // Zero-wait: respond straight from the live setup request.
                        w_pready_nxt  = 1'b1;
                        w_pslverr_nxt = w_addr_err;
                        if (!s_apb.pwrite && !w_addr_err) begin
                            w_prdata_nxt = r_mem[w_addr_idx];
                        end
                    end else begin
                        w_cnt_nxt = LP_WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (s_apb.psel) begin
                    if (r_cnt == 4'd0) begin
                        w_pready_nxt  = 1'b1;
                        w_pslverr_nxt = r_err;
                        if (!r_write && !r_err) begin
                            w_prdata_nxt = r_mem[r_idx];
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
            end
            ST_RESP: begin
                // Write commits on the edge that closes the response cycle,
                // and only if the master still holds PSEL.
                w_mem_we = s_apb.psel & r_write & ~r_err;
            end
            default: begin
                w_mem_we = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs, wait counter and request latch
    // ------------------------------------------------------------------
    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
            r_cnt     <= 4'd0;
            r_idx     <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_pready  <= w_pready_nxt;
            r_pslverr <= w_pslverr_nxt;
            r_prdata  <= w_prdata_nxt;
            r_cnt     <= w_cnt_nxt;
            if (w_latch) begin
                r_idx   <= w_addr_idx;
                r_write <= s_apb.pwrite;
                r_wdata <= s_apb.pwdata;
                r_err   <= w_addr_err;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register memory, cleared by reset
    // ------------------------------------------------------------------
    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_mem_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign s_apb.pready  = r_pready;
    assign s_apb.pslverr = r_pslverr;
    assign s_apb.prdata  = r_prdata;

endmodule
